// File: rtl/risc_v_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : risc_v_fetch_stage_pkg
//  Brief    : Shared fetch-stage types and constants (buffer entry layout,
//             reset PC, PC increment, opcode field position).
//  Revision : 1.0  initial release
// ============================================================================
package risc_v_fetch_stage_pkg;

    // Opcode occupies instr[INST_OPCODE_MSB:0]
    localparam int          INST_OPCODE_MSB = 6;
    localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP         = 32'd4;

    // One instruction-buffer slot: the fetched word and the PC it came from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } t_fetch_entry;

endpackage
`default_nettype wire

// File: rtl/risc_v_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : risc_v_sync_fifo
//  Brief    : Single-clock FIFO of arbitrary element type. Head is shown
//             combinationally; push and pop in one cycle are both honoured
//             even when full. Flush empties it and wins over push/pop.
//  Revision : 1.0  initial release
// ============================================================================
module risc_v_sync_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output T                       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    T                r_mem [DEPTH];
    logic            w_do_push;
    logic            w_do_pop;

    // A pop frees the head slot in the same cycle, so a full FIFO may still push
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign full     = (r_count == c_cw'(DEPTH));
    assign empty    = (r_count == '0);

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + c_cw'(w_do_push) - c_cw'(w_do_pop);
        end
    end

    // Storage is cleared on reset so the exposed head reads as zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/risc_v_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : risc_v_fetch_stage
//  Brief    : Instruction fetch. Owns the PC, issues credit-limited in-order
//             word reads, pairs responses with their PC and presents them to
//             decode. A redirect flushes everything fetched or in flight.
//  Revision : 1.0  initial release
// ============================================================================
module risc_v_fetch_stage
    import risc_v_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [31:0]                imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [31:0]                dec_instr,
    output logic [31:0]                dec_pc,
    output logic [INST_OPCODE_MSB:0]   dec_opcode
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam int c_sum_w = c_cnt_w + 1;

    logic [31:0]        r_pc;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_drop;
    logic               r_run;

    logic [c_cnt_w-1:0] w_buf_count;
    logic [c_cnt_w-1:0] w_pcq_count;
    logic               w_buf_full;
    logic               w_buf_empty;
    logic               w_pcq_full;
    logic               w_pcq_empty;
    logic [31:0]        w_pcq_head;
    t_fetch_entry       w_buf_head;
    t_fetch_entry       w_buf_push;
    logic [c_sum_w-1:0] w_credit_used;
    logic               w_accept;
    logic               w_rsp_take;
    logic               w_rsp_keep;
    logic               w_dec_fire;

    // Every issued request owns a buffer slot, so responses can never be refused
    assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_buf_count};
    assign imem_req_valid = r_run && !redirect_valid
                         && (w_credit_used < c_sum_w'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are stray and ignored entirely
    assign w_rsp_take = imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_keep = w_rsp_take && (r_drop == '0) && !redirect_valid;

    assign w_buf_push = '{pc: w_pcq_head, instr: imem_rsp_data};
    assign dec_valid  = !w_buf_empty;
    assign dec_pc     = w_buf_head.pc;
    assign dec_instr  = w_buf_head.instr;
    assign dec_opcode = w_buf_head.instr[INST_OPCODE_MSB:0];
    assign w_dec_fire = dec_valid && dec_ready;

    // PC, in-flight and drop counters. On redirect every request still
    // outstanding after this cycle belongs to the dead path, so drop is
    // simply the post-cycle outstanding count (old drops are a subset of it).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_run         <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid) begin
                r_pc          <= {redirect_pc[31:2], 2'b00};
                r_outstanding <= r_outstanding - c_cnt_w'(w_rsp_take);
                r_drop        <= r_outstanding - c_cnt_w'(w_rsp_take);
            end else begin
                if (w_accept) r_pc <= r_pc + PC_STEP;
                r_outstanding <= r_outstanding + c_cnt_w'(w_accept) - c_cnt_w'(w_rsp_take);
                if (w_rsp_take && (r_drop != '0)) r_drop <= r_drop - 1'b1;
            end
        end
    end

    // PCs of live (not-to-be-dropped) requests, oldest first
    risc_v_sync_fifo #(
        .T     (logic [31:0]),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_accept),
        .push_data (r_pc),
        .pop       (w_rsp_keep),
        .flush     (redirect_valid),
        .pop_data  (w_pcq_head),
        .count     (w_pcq_count),
        .full      (w_pcq_full),
        .empty     (w_pcq_empty)
    );

    // Fetched {pc, instr} awaiting decode
    risc_v_sync_fifo #(
        .T     (t_fetch_entry),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_rsp_keep),
        .push_data (w_buf_push),
        .pop       (w_dec_fire),
        .flush     (redirect_valid),
        .pop_data  (w_buf_head),
        .count     (w_buf_count),
        .full      (w_buf_full),
        .empty     (w_buf_empty)
    );

`ifndef SYNTHESIS
    // Bookkeeping invariants and memory-protocol sanity, checked every edge outside reset
    always @(posedge clk) begin
        if (rst_n) begin
            a_outstanding_max: assert (r_outstanding <= c_cnt_w'(FIFO_DEPTH));
            a_drop_le_out:     assert (r_drop <= r_outstanding);
            a_stray_rsp:       assert (!(imem_rsp_valid && (r_outstanding == '0)));
            a_pcq_track:       assert ({1'b0, w_pcq_count} + {1'b0, r_drop} == {1'b0, r_outstanding});
            a_pcq_has_pc:      assert (!(w_rsp_keep && w_pcq_empty));
            a_pcq_room:        assert (!(w_accept && w_pcq_full && !w_rsp_keep));
            a_buf_room:        assert (!(w_rsp_keep && w_buf_full && !w_dec_fire));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_risc_v_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_risc_v_fetch_stage
//  Brief    : Directed and randomised bench for risc_v_fetch_stage with an
//             in-order instruction-memory model and a decode-side PC scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_risc_v_fetch_stage;

    localparam logic [31:0] XORK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_instr, dec_pc;
    logic [6:0]  dec_opcode;

    // second instance, only exercises the reset-PC wrap
    logic        req_valid_2, req_ready_2 = 1'b1;
    logic [31:0] req_addr_2;
    logic        rsp_valid_2 = 1'b0;
    logic [31:0] rsp_data_2  = 32'h0;
    logic        redir_2 = 1'b0;
    logic [31:0] redir_pc_2 = 32'h0;
    logic        dec_valid_2, dec_ready_2 = 1'b1;
    logic [31:0] dec_instr_2, dec_pc_2;
    logic [6:0]  dec_opcode_2;

    int total = 0;
    int bad   = 0;

    // memory model state
    int          lat      = 1;
    bit          rand_lat = 0;
    bit          rdy_rand = 0;
    int          ncyc     = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] acc_log[$];
    logic [31:0] log_2[$];
    bit          pend_2 = 0;
    logic [31:0] pend_addr_2 = 32'h0;

    // scoreboard state
    logic [31:0] exp_pc = 32'h0;
    int          n_dec  = 0;

    always #5 clk = ~clk;

    risc_v_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_opcode     (dec_opcode)
    );

    risc_v_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (req_valid_2),
        .imem_req_ready (req_ready_2),
        .imem_req_addr  (req_addr_2),
        .imem_rsp_valid (rsp_valid_2),
        .imem_rsp_data  (rsp_data_2),
        .redirect_valid (redir_2),
        .redirect_pc    (redir_pc_2),
        .dec_valid      (dec_valid_2),
        .dec_ready      (dec_ready_2),
        .dec_instr      (dec_instr_2),
        .dec_pc         (dec_pc_2),
        .dec_opcode     (dec_opcode_2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // In-order memory: handshakes sampled at negedge, outputs driven 1 after posedge
    always begin
        @(negedge clk);
        if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (imem_rsp_valid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(ncyc + (rand_lat ? int'($urandom_range(4, 1)) : lat));
                acc_log.push_back(imem_req_addr);
            end
        end
        ncyc++;
        @(posedge clk);
        #1;
        imem_req_ready = rdy_rand ? (($urandom % 2) == 1) : 1'b1;
        if (rst_n && (mq_addr.size() > 0) && (mq_due[0] <= ncyc)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq_addr[0] ^ XORK;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    end

    // One-cycle memory for the second instance
    always begin
        @(negedge clk);
        if (!rst_n) begin
            log_2.delete();
            pend_2 = 0;
        end else begin
            pend_2 = req_valid_2;
            pend_addr_2 = req_addr_2;
            if (req_valid_2) log_2.push_back(req_addr_2);
        end
        @(posedge clk);
        #1;
        rsp_valid_2 = pend_2 && rst_n;
        rsp_data_2  = pend_addr_2 ^ XORK;
    end

    // Decode scoreboard: golden PC sequence restarts at each redirect target
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = 32'h0;
        end else if (redirect_valid) begin
            exp_pc = {redirect_pc[31:2], 2'b00};
        end else if (dec_valid && dec_ready) begin
            chk("sb_pc", dec_pc, exp_pc);
            chk("sb_instr", dec_instr, exp_pc ^ XORK);
            chk("sb_opcode", {25'b0, dec_opcode}, {25'b0, exp_pc[6:0]});
            exp_pc = exp_pc + 32'd4;
            n_dec++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_acc(input string tag, input int idx, output logic [31:0] addr);
        int k = 0;
        while ((acc_log.size() <= idx) && (k < 60)) begin tick(); k++; end
        total++;
        assert (k < 60) else begin
            bad++;
            $error("FAIL %s_timeout: observed=%0d expected=<60", tag, k);
        end
        addr = (acc_log.size() > idx) ? acc_log[idx] : 32'hXXXX_XXXX;
    endtask

    task automatic wait_dec_valid(input string tag);
        int k = 0;
        while (!dec_valid && (k < 60)) begin tick(); k++; end
        total++;
        assert (k < 60) else begin
            bad++;
            $error("FAIL %s_timeout: observed=%0d expected=<60", tag, k);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          idx;
        int          k;
        int          nd0;

        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        // reset values
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_req_addr_2", req_addr_2, 32'hFFFF_FFF8);

        // 1: streaming with 1-cycle memory
        dec_ready = 1'b1;
        idx = acc_log.size();
        nd0 = n_dec;
        #1 rst_n = 1'b1;
        wait_acc("t1_acc", idx, a);
        chk("t1_first_addr", a, 32'h0);
        wait_dec_valid("t1_dec");
        chk("t1_first_pc", dec_pc, 32'h0);
        chk("t1_first_instr", dec_instr, XORK);
        k = 0;
        while ((n_dec < nd0 + 12) && (k < 60)) begin tick(); k++; end
        chk("t1_progress", {31'b0, n_dec >= nd0 + 12}, 32'd1);

        // 5: wrap of the PC from the high reset address
        chk("t5_log_size", {31'b0, log_2.size() >= 4}, 32'd1);
        if (log_2.size() >= 4) begin
            chk("t5_addr0", log_2[0], 32'hFFFF_FFF8);
            chk("t5_addr1", log_2[1], 32'hFFFF_FFFC);
            chk("t5_addr2", log_2[2], 32'h0000_0000);
            chk("t5_addr3", log_2[3], 32'h0000_0004);
        end

        // 2: decode stalled -> exactly FIFO_DEPTH requests
        dec_ready = 1'b0;
        apply_reset();
        idx = acc_log.size();
        repeat (10) tick();
        chk("t2_req_count", acc_log.size() - idx, 32'd2);
        chk("t2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("t2_req_addr", imem_req_addr, 32'h8);
        chk("t2_dec_valid", {31'b0, dec_valid}, 32'd1);
        chk("t2_dec_pc", dec_pc, 32'h0);
        idx = acc_log.size();
        dec_ready = 1'b1;
        wait_acc("t2_resume", idx, a);
        chk("t2_resume_addr", a, 32'h8);
        repeat (6) tick();

        // 3: redirect with two requests in flight, 3-cycle latency
        lat = 3;
        apply_reset();
        idx = acc_log.size();
        wait_acc("t3_acc0", idx, a);
        chk("t3_acc0_addr", a, 32'h0);
        wait_acc("t3_acc1", idx + 1, a);
        chk("t3_acc1_addr", a, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        chk("t3_no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        chk("t3_dec_valid_after", {31'b0, dec_valid}, 32'd0);
        idx = acc_log.size();
        wait_acc("t3_target", idx, a);
        chk("t3_target_addr", a, 32'h0000_0100);
        wait_dec_valid("t3_dec");
        chk("t3_first_dec_pc", dec_pc, 32'h0000_0100);
        chk("t3_first_dec_instr", dec_instr, 32'h0000_0100 ^ XORK);
        repeat (6) tick();

        // 4: redirect coinciding with a response and a would-be accept
        lat = 1;
        apply_reset();
        k = 0;
        tick();
        while (!(imem_rsp_valid && imem_req_valid) && (k < 40)) begin tick(); k++; end
        chk("t4_setup_found", {31'b0, k < 40}, 32'd1);
        idx = acc_log.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        chk("t4_no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        wait_acc("t4_target", idx, a);
        chk("t4_target_addr", a, 32'h0000_0200);
        wait_dec_valid("t4_dec");
        chk("t4_first_dec_pc", dec_pc, 32'h0000_0200);
        repeat (6) tick();

        // 6: random ready / latency / redirects / decode stalls, plus one mid-run reset
        rand_lat = 1;
        rdy_rand = 1;
        apply_reset();
        nd0 = n_dec;
        for (int i = 0; i < 1500; i++) begin
            tick();
            dec_ready = ($urandom % 4) != 0;
            if (i == 750) begin
                redirect_valid = 1'b0;
                #1 rst_n = 1'b0;
                #1;
                chk("t6_midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
                chk("t6_midrst_req_addr", imem_req_addr, 32'h0);
                chk("t6_midrst_dec_valid", {31'b0, dec_valid}, 32'd0);
                chk("t6_midrst_dec_pc", dec_pc, 32'h0);
                repeat (2) @(posedge clk);
                #3 rst_n = 1'b1;
            end else if (($urandom % 40) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
        end
        tick();
        redirect_valid = 1'b0;
        dec_ready = 1'b1;
        repeat (20) tick();
        chk("t6_progress", {31'b0, (n_dec - nd0) >= 50}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
